// File: rtl/bidin_deint.sv
`default_nettype none
// ============================================================================
// Module   : bidin_deint
// Purpose  : Ping-pong soft-bit block deinterleaver. Soft values arrive
//            row-major into a ROWS x COLS block and leave column-major on
//            LDPC decoder request. One bank is written while the other is
//            read; a block is released after CW_PER_BLK decoded codewords.
// Revision : 1.0  initial release
// ============================================================================
module bidin_deint #(
    parameter int WID         = 6,
    parameter int ROWS        = 384,
    parameter int COLS        = 360,
    parameter int CW_PER_BLK  = 15,
    parameter int FULL_MARGIN = 4
) (
    input  logic           clk6,
    input  logic           rst_n,
    input  logic           bidin_sync_in,
    input  logic           bidin_ena_in,
    input  logic [WID-1:0] bidin_din,
    input  logic           ldpc_req,
    input  logic           ldpc_fin,
    output logic           bidin_full,
    output logic           bidin_rdy,
    output logic           bidin_ena_out,
    output logic [WID-1:0] bidin_dout
);

    localparam int c_BLK = ROWS * COLS;
    localparam int c_IW  = (c_BLK > 1) ? $clog2(c_BLK) : 1;       // in-block index
    localparam int c_NW  = $clog2(c_BLK + 1);                      // read count 0..BLK
    localparam int c_RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_CW  = $clog2(COLS + 1);                       // column 0..COLS
    localparam int c_FW  = (CW_PER_BLK > 1) ? $clog2(CW_PER_BLK) : 1;

    localparam logic [c_IW-1:0] c_K_LAST = c_IW'(c_BLK - 1);
    localparam logic [c_IW-1:0] c_K_WARN = c_IW'(c_BLK - FULL_MARGIN);
    localparam logic [c_IW-1:0] c_COLS_A = c_IW'(COLS);
    localparam logic [c_NW-1:0] c_N_BLK  = c_NW'(c_BLK);
    localparam logic [c_RW-1:0] c_R_LAST = c_RW'(ROWS - 1);
    localparam logic [c_FW-1:0] c_F_LAST = c_FW'(CW_PER_BLK - 1);

    // Storage: two banks, each one full interleaver block
    logic [WID-1:0] bank_mem [2][c_BLK];

    logic            armed_q,    armed_d;
    logic            wr_bank_q,  wr_bank_d;
    logic            rd_bank_q,  rd_bank_d;
    logic [1:0]      bank_full_q, bank_full_d;
    logic [c_IW-1:0] wr_k_q,     wr_k_d;
    logic [c_IW-1:0] rd_addr_q,  rd_addr_d;
    logic [c_NW-1:0] rd_n_q,     rd_n_d;
    logic [c_RW-1:0] rd_r_q,     rd_r_d;
    logic [c_CW-1:0] rd_c_q,     rd_c_d;
    logic [c_FW-1:0] fin_cnt_q,  fin_cnt_d;
    logic            full_q,     full_d;
    logic            rdy_q,      rdy_d;
    logic            ena_out_q,  ena_out_d;
    logic [WID-1:0]  dout_q,     dout_d;

    logic            wr_en;
    logic            rd_en;
    logic            release_blk;
    logic [WID-1:0]  rd_data;

    assign rd_data = bank_mem[rd_bank_q][rd_addr_q];

    // Next-state: arming, write addressing, column-major read walk, release
    always_comb begin
        armed_d     = armed_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        wr_k_d      = wr_k_q;
        rd_addr_d   = rd_addr_q;
        rd_n_d      = rd_n_q;
        rd_r_d      = rd_r_q;
        rd_c_d      = rd_c_q;
        fin_cnt_d   = fin_cnt_q;

        // Syncs only take effect on a block boundary (nothing written yet)
        if (bidin_sync_in && (wr_k_q == '0)) begin
            armed_d = 1'b1;
        end

        // Values arriving while the write bank is still occupied are dropped
        wr_en = armed_q && bidin_ena_in && !bank_full_q[wr_bank_q];
        if (wr_en) begin
            if (wr_k_q == c_K_LAST) begin
                wr_k_d                 = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                wr_k_d = wr_k_q + 1'b1;
            end
        end

        // Address steps down a column by +COLS; at the bottom row jump to
        // the top of the next column, which is simply the column index.
        rd_en     = ldpc_req && rdy_q && (rd_n_q != c_N_BLK);
        ena_out_d = rd_en;
        dout_d    = rd_en ? rd_data : dout_q;
        if (rd_en) begin
            rd_n_d = rd_n_q + 1'b1;
            if (rd_r_q == c_R_LAST) begin
                rd_r_d    = '0;
                rd_c_d    = rd_c_q + 1'b1;
                rd_addr_d = c_IW'(rd_c_d);
            end else begin
                rd_r_d    = rd_r_q + 1'b1;
                rd_addr_d = rd_addr_q + c_COLS_A;
            end
        end

        // The last decoded codeword of a block hands its bank back
        release_blk = ldpc_fin && rdy_q && (fin_cnt_q == c_F_LAST);
        if (ldpc_fin && rdy_q) begin
            fin_cnt_d = release_blk ? '0 : (fin_cnt_q + 1'b1);
        end
        if (release_blk) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            rd_n_d                 = '0;
            rd_r_d                 = '0;
            rd_c_d                 = '0;
            rd_addr_d              = '0;
        end

        // Flags are evaluated on the post-update state so they track the banks
        full_d = bank_full_d[wr_bank_d] ||
                 ((wr_k_d >= c_K_WARN) && bank_full_d[~wr_bank_d]);
        // Force one idle cycle on release so the decoder sees a block boundary
        rdy_d  = !release_blk && bank_full_d[rd_bank_d];
    end

    // Block RAM write port (contents are not reset)
    always_ff @(posedge clk6) begin
        if (wr_en) begin
            bank_mem[wr_bank_q][wr_k_q] <= bidin_din;
        end
    end

    // Control and output registers
    always_ff @(posedge clk6 or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            wr_k_q      <= '0;
            rd_addr_q   <= '0;
            rd_n_q      <= '0;
            rd_r_q      <= '0;
            rd_c_q      <= '0;
            fin_cnt_q   <= '0;
            full_q      <= 1'b0;
            rdy_q       <= 1'b0;
            ena_out_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            armed_q     <= armed_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            wr_k_q      <= wr_k_d;
            rd_addr_q   <= rd_addr_d;
            rd_n_q      <= rd_n_d;
            rd_r_q      <= rd_r_d;
            rd_c_q      <= rd_c_d;
            fin_cnt_q   <= fin_cnt_d;
            full_q      <= full_d;
            rdy_q       <= rdy_d;
            ena_out_q   <= ena_out_d;
            dout_q      <= dout_d;
        end
    end

    assign bidin_full    = full_q;
    assign bidin_rdy     = rdy_q;
    assign bidin_ena_out = ena_out_q;
    assign bidin_dout    = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_bidin_deint.sv
`default_nettype none
// ============================================================================
// Module   : tb_bidin_deint
// Purpose  : Self-checking bench for bidin_deint on a small 4x3 block with
//            a queue-based reference model plus literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_bidin_deint;

    localparam int WID  = 6;
    localparam int ROWS = 4;
    localparam int COLS = 3;
    localparam int CW   = 3;
    localparam int FM   = 4;
    localparam int BLK  = ROWS * COLS;

    logic           clk6 = 1'b0;
    logic           rst_n = 1'b1;
    logic           bidin_sync_in = 1'b0;
    logic           bidin_ena_in = 1'b0;
    logic [WID-1:0] bidin_din = '0;
    logic           ldpc_req = 1'b0;
    logic           ldpc_fin = 1'b0;
    logic           bidin_full;
    logic           bidin_rdy;
    logic           bidin_ena_out;
    logic [WID-1:0] bidin_dout;

    int checks = 0;
    int errors = 0;

    bidin_deint #(
        .WID(WID), .ROWS(ROWS), .COLS(COLS),
        .CW_PER_BLK(CW), .FULL_MARGIN(FM)
    ) dut (
        .clk6          (clk6),
        .rst_n         (rst_n),
        .bidin_sync_in (bidin_sync_in),
        .bidin_ena_in  (bidin_ena_in),
        .bidin_din     (bidin_din),
        .ldpc_req      (ldpc_req),
        .ldpc_fin      (ldpc_fin),
        .bidin_full    (bidin_full),
        .bidin_rdy     (bidin_rdy),
        .bidin_ena_out (bidin_ena_out),
        .bidin_dout    (bidin_dout)
    );

    always #5 clk6 = ~clk6;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (block-level view) ----------------
    bit m_armed;
    int m_part[$];      // values of the block being written
    int m_blk[$];       // completed blocks, oldest first, BLK values each
    int m_rd_n, m_fin, m_dout;
    bit m_rdy, m_full, m_ena;

    initial begin
        forever begin
            @(posedge clk6 or negedge rst_n);
            if (!rst_n) begin
                m_armed = 0; m_part.delete(); m_blk.delete();
                m_rd_n = 0; m_fin = 0; m_rdy = 0; m_full = 0; m_ena = 0; m_dout = 0;
            end else begin
                bit rel, arm;
                int nfull;
                arm = bidin_sync_in && (m_part.size() == 0);
                m_ena = 0;
                if (ldpc_req && m_rdy && m_rd_n < BLK) begin
                    // output n is row n%ROWS, column n/ROWS of the oldest block
                    m_dout = m_blk[(m_rd_n % ROWS) * COLS + m_rd_n / ROWS];
                    m_ena = 1;
                    m_rd_n++;
                end
                rel = 0;
                if (ldpc_fin && m_rdy) begin
                    m_fin++;
                    if (m_fin == CW) rel = 1;
                end
                nfull = m_blk.size() / BLK;
                if (m_armed && bidin_ena_in && nfull < 2) begin
                    m_part.push_back(int'(bidin_din));
                    if (m_part.size() == BLK) begin
                        foreach (m_part[i]) m_blk.push_back(m_part[i]);
                        m_part.delete();
                    end
                end
                if (arm) m_armed = 1;
                if (rel) begin
                    repeat (BLK) void'(m_blk.pop_front());
                    m_rd_n = 0; m_fin = 0;
                end
                nfull = m_blk.size() / BLK;
                m_rdy  = !rel && nfull > 0;
                m_full = (nfull == 2) || (m_part.size() >= BLK - FM && nfull == 1);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk6);
            chk("model_full", bidin_full, m_full);
            chk("model_rdy",  bidin_rdy,  m_rdy);
            chk("model_ena",  bidin_ena_out, m_ena);
            chk("model_dout", bidin_dout, m_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync_pulse();
        @(negedge clk6); bidin_sync_in = 1'b1;
        @(negedge clk6); bidin_sync_in = 1'b0;
    endtask

    task automatic write_seq(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk6); bidin_ena_in = 1'b1; bidin_din = WID'(base + i);
        end
        @(negedge clk6); bidin_ena_in = 1'b0;
    endtask

    task automatic read_n(input int n);
        @(negedge clk6); ldpc_req = 1'b1;
        repeat (n) @(negedge clk6);
        ldpc_req = 1'b0;
    endtask

    task automatic fin_n(input int n);
        repeat (n) begin
            @(negedge clk6); ldpc_fin = 1'b1;
            @(negedge clk6); ldpc_fin = 1'b0;
        end
    endtask

    task automatic wait_rdy(input int budget);
        int k = 0;
        while (!bidin_rdy && k < budget) begin
            @(negedge clk6); k++;
        end
        chk("wait_rdy", bidin_rdy, 1'b1);
    endtask

    task automatic read_check_order(input string tag);
        int expv[12];
        expv = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        @(negedge clk6); ldpc_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk6);
            chk({tag, "_ena"},  bidin_ena_out, 1'b1);
            chk({tag, "_dout"}, bidin_dout, expv[i]);
            if (i == 11) ldpc_req = 1'b0;
        end
        @(negedge clk6);
        chk({tag, "_ena_after"}, bidin_ena_out, 1'b0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // 1. reset with random inputs
        #2 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk6);
            bidin_sync_in = 1'($urandom_range(0, 1));
            bidin_ena_in  = 1'($urandom_range(0, 1));
            bidin_din     = WID'($urandom);
            ldpc_req      = 1'($urandom_range(0, 1));
            ldpc_fin      = 1'($urandom_range(0, 1));
        end
        @(negedge clk6);
        chk("rst_full", bidin_full, 1'b0);
        chk("rst_rdy",  bidin_rdy,  1'b0);
        chk("rst_ena",  bidin_ena_out, 1'b0);
        chk("rst_dout", bidin_dout, 0);
        bidin_sync_in = 0; bidin_ena_in = 0; bidin_din = '0; ldpc_req = 0; ldpc_fin = 0;
        @(negedge clk6); rst_n = 1'b1;

        // 2. ordering
        sync_pulse();
        write_seq(0, 11);
        chk("s2_rdy_before", bidin_rdy, 1'b0);
        write_seq(11, 1);
        chk("s2_rdy_after", bidin_rdy, 1'b1);
        chk("s2_full", bidin_full, 1'b0);
        read_check_order("s2");
        fin_n(CW);
        chk("s2_rdy_released", bidin_rdy, 1'b0);

        // 3. arming after a mid-operation reset
        @(posedge clk6); #1 rst_n = 1'b0;
        @(negedge clk6); rst_n = 1'b1;
        write_seq(40, 5);
        sync_pulse();
        write_seq(0, 12);
        chk("s3_rdy", bidin_rdy, 1'b1);
        read_check_order("s3");
        fin_n(CW);
        chk("s3_rdy_released", bidin_rdy, 1'b0);

        // 4. back-pressure: fill both banks without reading
        write_seq(16, 12);
        chk("s4_rdy_a", bidin_rdy, 1'b1);
        write_seq(32, 7);
        chk("s4_full_k7", bidin_full, 1'b0);
        write_seq(39, 1);
        chk("s4_full_k8", bidin_full, 1'b1);
        write_seq(40, 7);
        chk("s4_full_both", bidin_full, 1'b1);
        read_n(BLK);
        fin_n(CW);
        chk("s4_full_cleared", bidin_full, 1'b0);
        chk("s4_rdy_gap", bidin_rdy, 1'b0);
        @(negedge clk6);
        chk("s4_rdy_b", bidin_rdy, 1'b1);
        read_n(BLK);
        fin_n(CW);

        // 5. idle read and idle fin
        chk("s5_rdy_idle", bidin_rdy, 1'b0);
        read_n(4);
        chk("s5_ena_idle", bidin_ena_out, 1'b0);
        fin_n(4);
        write_seq(8, 12);
        chk("s5_rdy_c", bidin_rdy, 1'b1);
        fin_n(CW - 1);
        chk("s5_rdy_kept", bidin_rdy, 1'b1);
        read_n(BLK);
        fin_n(1);
        chk("s5_rdy_released", bidin_rdy, 1'b0);

        // 6. ping-pong: stream A and B while reading A
        fork
            write_seq(0, 2 * BLK);
            begin
                wait_rdy(40);
                read_n(BLK);
                fin_n(CW);
                chk("s6_rdy_drop", bidin_rdy, 1'b0);
                @(negedge clk6);
                chk("s6_rdy_rise", bidin_rdy, 1'b1);
                read_n(BLK);
                fin_n(CW);
            end
        join
        chk("s6_rdy_end", bidin_rdy, 1'b0);

        repeat (2) @(negedge clk6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
